// File: rtl/beverage_dispenser_ctrl.sv
// Beverage vending controller: coin credit, priced selection, recipe-driven valve
// sequencing with a sugar level, and change return.
module beverage_dispenser_ctrl #(
    parameter int unsigned CREDIT_W    = 10,
    parameter int unsigned N_DRINKS    = 4,
    parameter int unsigned COIN_A      = 100,
    parameter int unsigned COIN_B      = 500,
    parameter int unsigned MAX_CREDIT  = 1000,
    parameter int unsigned STEP_CYCLES = 4,
    parameter logic [N_DRINKS*CREDIT_W-1:0] PRICES = {10'd500, 10'd600, 10'd400, 10'd300},
    parameter logic [N_DRINKS*5-1:0] RECIPES = {5'b10111, 5'b11111, 5'b11101, 5'b11001},
    localparam int unsigned SEL_W = (N_DRINKS > 1) ? $clog2(N_DRINKS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_coin_100,
    input  logic                i_coin_500,
    input  logic [SEL_W-1:0]    i_drink_sel,
    input  logic                i_select,
    input  logic                i_cancel,
    input  logic [1:0]          i_sugar_lvl,
    output logic [CREDIT_W-1:0] o_credit,
    output logic [CREDIT_W-1:0] o_change,
    output logic                o_change_valid,
    output logic                o_water,
    output logic                o_coffee,
    output logic                o_milk,
    output logic                o_chocolate,
    output logic                o_sugar,
    output logic                o_busy,
    output logic                o_finished,
    output logic                o_reject,
    output logic                o_deny
);

    localparam int unsigned CNT_W = $clog2(3 * STEP_CYCLES + 1);
    localparam int unsigned SUM_W = CREDIT_W + 1;
    localparam int unsigned ACC_W = CREDIT_W + 2;

    typedef enum logic [1:0] {StIdle, StDispense, StChange} state_t;

    state_t              r_state;
    logic                r_coin_100_prev;
    logic                r_coin_500_prev;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_price;
    logic [CREDIT_W-1:0] r_change;
    logic [4:0]          r_recipe;
    logic [1:0]          r_sugar;
    logic [2:0]          r_step;
    logic [CNT_W-1:0]    r_cnt;
    logic [4:0]          r_valves;
    logic                r_change_valid;
    logic                r_busy;
    logic                r_finished;
    logic                r_reject;
    logic                r_deny;

    logic                w_edge_a;
    logic                w_edge_b;
    logic                w_any_coin;
    logic [SUM_W-1:0]    w_sum;
    logic                w_coin_fits;
    logic                w_sel_valid;
    logic [CREDIT_W-1:0] w_sel_price;
    logic [4:0]          w_sel_recipe;
    logic                w_afford;
    logic [3:0]          w_first;
    logic [3:0]          w_next;

    // Step order: 0 water, 1 coffee, 2 milk, 3 chocolate, 4 sugar.
    function automatic logic step_en(input logic [2:0] idx, input logic [4:0] rec,
                                     input logic [1:0] sug);
        logic en;
        unique case (idx)
            3'd0:    en = rec[4];
            3'd1:    en = rec[3];
            3'd2:    en = rec[2];
            3'd3:    en = rec[1];
            3'd4:    en = rec[0] && (sug != 2'd0);
            default: en = 1'b0;
        endcase
        return en;
    endfunction

    // Returns {found, index} of the first enabled step at or after start_idx.
    function automatic logic [3:0] first_step(input logic [2:0] start_idx,
                                              input logic [4:0] rec, input logic [1:0] sug);
        logic       found;
        logic [2:0] idx;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < 5; k++) begin
            if (!found && k >= int'(start_idx) && step_en(3'(k), rec, sug)) begin
                found = 1'b1;
                idx   = 3'(k);
            end
        end
        return {found, idx};
    endfunction

    // Counter load value: remaining cycles after the first one of the step.
    function automatic logic [CNT_W-1:0] step_len(input logic [2:0] idx, input logic [1:0] sug);
        if (idx == 3'd4) begin
            return CNT_W'(STEP_CYCLES * 32'(sug) - 32'd1);
        end
        return CNT_W'(STEP_CYCLES - 32'd1);
    endfunction

    assign w_edge_a    = i_coin_100 & ~r_coin_100_prev;
    assign w_edge_b    = i_coin_500 & ~r_coin_500_prev;
    assign w_any_coin  = w_edge_a | w_edge_b;
    assign w_sum       = (w_edge_a ? SUM_W'(COIN_A) : '0) + (w_edge_b ? SUM_W'(COIN_B) : '0);
    assign w_coin_fits = (ACC_W'(r_credit) + ACC_W'(w_sum)) <= ACC_W'(MAX_CREDIT);
    assign w_sel_valid = 32'(i_drink_sel) < N_DRINKS;
    assign w_afford    = r_credit >= w_sel_price;
    assign w_first     = first_step(3'd0, w_sel_recipe, i_sugar_lvl);
    assign w_next      = first_step(r_step + 3'd1, r_recipe, r_sugar);

    always_comb begin
        w_sel_price  = '0;
        w_sel_recipe = '0;
        for (int unsigned i = 0; i < N_DRINKS; i++) begin
            if (i_drink_sel == SEL_W'(i)) begin
                w_sel_price  = PRICES[i*CREDIT_W +: CREDIT_W];
                w_sel_recipe = RECIPES[i*5 +: 5];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= StIdle;
            r_coin_100_prev <= 1'b1;
            r_coin_500_prev <= 1'b1;
            r_credit        <= '0;
            r_price         <= '0;
            r_change        <= '0;
            r_recipe        <= '0;
            r_sugar         <= '0;
            r_step          <= '0;
            r_cnt           <= '0;
            r_valves        <= '0;
            r_change_valid  <= 1'b0;
            r_busy          <= 1'b0;
            r_finished      <= 1'b0;
            r_reject        <= 1'b0;
            r_deny          <= 1'b0;
        end else begin
            r_coin_100_prev <= i_coin_100;
            r_coin_500_prev <= i_coin_500;
            r_change_valid  <= 1'b0;
            r_finished      <= 1'b0;
            r_reject        <= 1'b0;
            r_deny          <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_cancel) begin
                        r_reject <= w_any_coin;
                        if (r_credit != '0) begin
                            r_change       <= r_credit;
                            r_change_valid <= 1'b1;
                            r_credit       <= '0;
                        end
                    end else if (i_select && w_sel_valid && w_afford) begin
                        r_reject <= w_any_coin;
                        r_price  <= w_sel_price;
                        r_recipe <= w_sel_recipe;
                        r_sugar  <= i_sugar_lvl;
                        r_busy   <= 1'b1;
                        if (w_first[3]) begin
                            r_state  <= StDispense;
                            r_step   <= w_first[2:0];
                            r_cnt    <= step_len(w_first[2:0], i_sugar_lvl);
                            r_valves <= 5'b10000 >> w_first[2:0];
                        end else begin
                            // Empty recipe: nothing to pour, settle immediately.
                            r_state        <= StChange;
                            r_change       <= r_credit - w_sel_price;
                            r_change_valid <= 1'b1;
                            r_finished     <= 1'b1;
                            r_credit       <= '0;
                        end
                    end else begin
                        r_deny <= i_select;
                        if (w_any_coin) begin
                            if (w_coin_fits) begin
                                r_credit <= r_credit + w_sum[CREDIT_W-1:0];
                            end else begin
                                r_reject <= 1'b1;
                            end
                        end
                    end
                end
                StDispense: begin
                    r_reject <= w_any_coin;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (w_next[3]) begin
                        r_step   <= w_next[2:0];
                        r_cnt    <= step_len(w_next[2:0], r_sugar);
                        r_valves <= 5'b10000 >> w_next[2:0];
                    end else begin
                        r_valves       <= '0;
                        r_state        <= StChange;
                        r_change       <= r_credit - r_price;
                        r_change_valid <= 1'b1;
                        r_finished     <= 1'b1;
                        r_credit       <= '0;
                    end
                end
                StChange: begin
                    r_reject <= w_any_coin;
                    r_busy   <= 1'b0;
                    r_state  <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_credit       = r_credit;
    assign o_change       = r_change;
    assign o_change_valid = r_change_valid;
    assign o_water        = r_valves[4];
    assign o_coffee       = r_valves[3];
    assign o_milk         = r_valves[2];
    assign o_chocolate    = r_valves[1];
    assign o_sugar        = r_valves[0];
    assign o_busy         = r_busy;
    assign o_finished     = r_finished;
    assign o_reject       = r_reject;
    assign o_deny         = r_deny;

endmodule

// File: tb/tb_beverage_dispenser_ctrl.sv
// Scoreboard bench for beverage_dispenser_ctrl: stimulus pushes expected events,
// monitors pop and compare when the DUT presents them.
module tb_beverage_dispenser_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_100, coin_500, select, cancel;
    logic [1:0] drink_sel, sugar_lvl;
    logic [9:0] credit, change;
    logic       change_valid, water, coffee, milk, chocolate, sugar, busy, finished, reject, deny;

    logic       select2, coin_500_2;
    logic [1:0] sel2;
    logic [9:0] credit2, change2;
    logic       change_valid2, water2, coffee2, milk2, chocolate2, sugar2;
    logic       busy2, finished2, reject2, deny2;

    always #5 clk = ~clk;

    beverage_dispenser_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_coin_100(coin_100), .i_coin_500(coin_500),
        .i_drink_sel(drink_sel), .i_select(select), .i_cancel(cancel), .i_sugar_lvl(sugar_lvl),
        .o_credit(credit), .o_change(change), .o_change_valid(change_valid), .o_water(water),
        .o_coffee(coffee), .o_milk(milk), .o_chocolate(chocolate), .o_sugar(sugar),
        .o_busy(busy), .o_finished(finished), .o_reject(reject), .o_deny(deny)
    );

    beverage_dispenser_ctrl #(
        .N_DRINKS(3),
        .PRICES({10'd600, 10'd400, 10'd300}),
        .RECIPES({5'b11101, 5'b11101, 5'b11001})
    ) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_coin_100(1'b0), .i_coin_500(coin_500_2),
        .i_drink_sel(sel2), .i_select(select2), .i_cancel(1'b0), .i_sugar_lvl(2'd0),
        .o_credit(credit2), .o_change(change2), .o_change_valid(change_valid2), .o_water(water2),
        .o_coffee(coffee2), .o_milk(milk2), .o_chocolate(chocolate2), .o_sugar(sugar2),
        .o_busy(busy2), .o_finished(finished2), .o_reject(reject2), .o_deny(deny2)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Expected event queues; reject/deny entries hold the credit expected at the pulse.
    int q_rej[$];
    int q_deny[$];
    int q_cred[$];
    int q_chg[$];   // (finished << 16) | change
    int q_seg[$];   // (valve vector << 16) | length
    int q_busy[$];
    int q_deny2[$];

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int seg(int v, int len);
        return (v << 16) | len;
    endfunction

    // Main DUT monitor.
    initial begin
        int prev_credit = 0;
        int seg_v = 0;
        int seg_len = 0;
        int busy_len = 0;
        int v;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_credit = int'(credit);
                seg_v = 0;
                seg_len = 0;
                busy_len = 0;
            end else begin
                if (reject) begin
                    if (q_rej.size() == 0) check("reject_unexpected", q_rej.size(), 1);
                    else check("reject_credit", int'(credit), q_rej.pop_front());
                end
                if (deny) begin
                    if (q_deny.size() == 0) check("deny_unexpected", q_deny.size(), 1);
                    else check("deny_credit", int'(credit), q_deny.pop_front());
                end
                if (int'(credit) != prev_credit) begin
                    if (q_cred.size() == 0) check("credit_unexpected", q_cred.size(), 1);
                    else check("credit", int'(credit), q_cred.pop_front());
                    prev_credit = int'(credit);
                end
                if (change_valid) begin
                    if (q_chg.size() == 0) check("change_unexpected", q_chg.size(), 1);
                    else check("change_fin", (int'(finished) << 16) | int'(change),
                               q_chg.pop_front());
                end else if (finished) begin
                    check("finished_without_change", int'(change_valid), 1);
                end
                v = int'({water, coffee, milk, chocolate, sugar});
                if (v != 0) check("valve_onehot", $countones(v), 1);
                if (v != seg_v) begin
                    if (seg_v != 0) begin
                        if (q_seg.size() == 0) check("segment_unexpected", q_seg.size(), 1);
                        else check("segment", seg(seg_v, seg_len), q_seg.pop_front());
                    end
                    seg_v = v;
                    seg_len = 1;
                end else begin
                    seg_len++;
                end
                if (busy) begin
                    busy_len++;
                end else if (busy_len != 0) begin
                    if (q_busy.size() == 0) check("busy_unexpected", q_busy.size(), 1);
                    else check("busy_cycles", busy_len, q_busy.pop_front());
                    busy_len = 0;
                end
            end
        end
    end

    // Monitor for the three-drink instance.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && deny2) begin
                if (q_deny2.size() == 0) check("dut3_deny_unexpected", q_deny2.size(), 1);
                else check("dut3_deny_credit", int'(credit2), q_deny2.pop_front());
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic coin(logic a, logic b);
        coin_100 = a;
        coin_500 = b;
        tick(1);
        coin_100 = 1'b0;
        coin_500 = 1'b0;
        tick(1);
    endtask

    task automatic do_select(logic [1:0] d, logic [1:0] s);
        drink_sel = d;
        sugar_lvl = s;
        select = 1'b1;
        tick(1);
        select = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick(1);
        cancel = 1'b0;
        tick(1);
    endtask

    task automatic wait_idle(int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick(1);
            k++;
        end
        check("idle_within_budget", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        coin_100 = 0; coin_500 = 0; select = 0; cancel = 0; drink_sel = 0; sugar_lvl = 0;
        select2 = 0; sel2 = 0; coin_500_2 = 0;
        tick(2);
        check("rst_credit", int'(credit), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valves", int'({water, coffee, milk, chocolate, sugar}), 0);
        check("rst_pulses", int'({change_valid, finished, reject, deny}), 0);
        rst_n = 1'b1;
        tick(2);

        // Coin accumulation.
        q_cred.push_back(100); coin(1, 0);
        q_cred.push_back(600); coin(0, 1);

        // Drink1 with sugar 2 at credit 600.
        q_seg.push_back(seg(5'b10000, 4));
        q_seg.push_back(seg(5'b01000, 4));
        q_seg.push_back(seg(5'b00100, 4));
        q_seg.push_back(seg(5'b00001, 8));
        q_chg.push_back((1 << 16) | 200);
        q_cred.push_back(0);
        q_busy.push_back(21);
        do_select(2'd1, 2'd2);
        wait_idle(40);
        tick(2);

        // Credit ceiling.
        q_cred.push_back(500); coin(0, 1);
        for (int c = 600; c <= 900; c += 100) begin
            q_cred.push_back(c); coin(1, 0);
        end
        q_rej.push_back(900); coin(0, 1);
        q_chg.push_back(900); q_cred.push_back(0); do_cancel();
        q_cred.push_back(500); coin(0, 1);
        q_rej.push_back(500); coin(1, 1);
        for (int c = 600; c <= 1000; c += 100) begin
            q_cred.push_back(c); coin(1, 0);
        end
        q_chg.push_back(1000); q_cred.push_back(0); do_cancel();

        // Insufficient credit, then refund.
        for (int c = 100; c <= 300; c += 100) begin
            q_cred.push_back(c); coin(1, 0);
        end
        q_deny.push_back(300); do_select(2'd2, 2'd0); tick(1);
        q_chg.push_back(300); q_cred.push_back(0); do_cancel();

        // Out-of-range selection on the three-drink build.
        repeat (2) begin
            coin_500_2 = 1'b1; tick(1); coin_500_2 = 1'b0; tick(1);
        end
        q_deny2.push_back(1000);
        sel2 = 2'd3; select2 = 1'b1; tick(1); select2 = 1'b0; tick(2);
        check("dut3_credit_kept", int'(credit2), 1000);
        check("dut3_not_busy", int'(busy2), 0);

        // Select and cancel together: refund wins.
        q_cred.push_back(500); coin(0, 1);
        q_cred.push_back(600); coin(1, 0);
        q_chg.push_back(600); q_cred.push_back(0);
        drink_sel = 2'd0; select = 1'b1; cancel = 1'b1; tick(1);
        select = 1'b0; cancel = 1'b0; tick(1);
        check("cancel_select_no_vend", int'(busy), 0);

        // Espresso with a coin in the select cycle.
        q_cred.push_back(500); coin(0, 1);
        q_cred.push_back(600); coin(1, 0);
        q_rej.push_back(600);
        q_seg.push_back(seg(5'b10000, 4));
        q_seg.push_back(seg(5'b01000, 4));
        q_chg.push_back((1 << 16) | 300);
        q_cred.push_back(0);
        q_busy.push_back(9);
        drink_sel = 2'd0; sugar_lvl = 2'd0; select = 1'b1; coin_100 = 1'b1;
        tick(1);
        select = 1'b0; coin_100 = 1'b0;
        @(negedge clk);
        check("espresso_first_water", int'(water), 1);
        check("espresso_first_busy", int'(busy), 1);
        wait_idle(30);
        tick(2);

        // Reset during the coffee step with coin_500 held through release.
        q_cred.push_back(500); coin(0, 1);
        q_seg.push_back(seg(5'b10000, 4));
        do_select(2'd0, 2'd0);
        tick(5);
        check("midvend_coffee", int'(coffee), 1);
        coin_500 = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midvend_rst_credit", int'(credit), 0);
        check("midvend_rst_busy", int'(busy), 0);
        check("midvend_rst_valves", int'({water, coffee, milk, chocolate, sugar}), 0);
        check("midvend_rst_pulses", int'({change_valid, finished, reject, deny}), 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        coin_500 = 1'b0;
        tick(2);
        check("held_coin_credit", int'(credit), 0);
        check("held_coin_busy", int'(busy), 0);

        tick(3);
        check("left_reject", q_rej.size(), 0);
        check("left_deny", q_deny.size(), 0);
        check("left_credit", q_cred.size(), 0);
        check("left_change", q_chg.size(), 0);
        check("left_segment", q_seg.size(), 0);
        check("left_busy", q_busy.size(), 0);
        check("left_dut3_deny", q_deny2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
